// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU clients, the arbiter and the
// response consumer. The master side is the client/consumer environment;
// the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_id;
  logic             rsp_err;

  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_result, rsp_id, rsp_err,
    output rsp_ready,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_result, rsp_id, rsp_err,
    input  rsp_ready,
    output busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer in front of a shared combinational ALU.
// One operation is in flight at a time: IDLE accepts, EXEC evaluates the
// registered operands, RESP holds the result until the consumer takes it.

// Combinational 32-bit style ALU (ADD, SUB, AND, OR, XOR, SLL).
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result
);
  // Operation decode; unused codes return zero.
  always_comb begin
    result = '0;
    case (alu_control)
      3'b000:  result = a + b;
      3'b001:  result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = a ^ b;
      3'b101:  result = a << b[4:0];
      default: result = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant0;
  logic             grant1;
  logic             op_illegal;
  logic [WIDTH-1:0] alu_result;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (op_q),
    .result      (alu_result)
  );

  // Codes 110 and 111 have no ALU meaning and are reported as errors.
  assign op_illegal = op_q[2] & op_q[1];

  // Grant only in IDLE and never while reset is held, so ready reads 0 in
  // reset; on a tie the requester that did not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == IDLE) && rst_n) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
  end

  // Next-state and datapath register updates for the accept/exec/respond loop.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          a_d          = grant1 ? bus.req1_a  : bus.req0_a;
          b_d          = grant1 ? bus.req1_b  : bus.req0_b;
          op_d         = grant1 ? bus.req1_op : bus.req0_op;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = op_illegal ? '0 : alu_result;
        rsp_err_d    = op_illegal;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a scoreboard queue receives the
// expected response when an operation is accepted and is popped when the
// arbiter presents its response.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         id;
    logic         err;
    logic [W-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference behaviour of one operation as seen on the response channel.
  function automatic exp_t model(input logic id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [2:0] op);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    e.res = '0;
    case (op)
      3'd0: e.res = a + b;
      3'd1: e.res = a + ~b + 32'd1;
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = (a | b) & ~(a & b);
      3'd5: e.res = a * (32'd1 << b[4:0]);
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic drive_req(input logic id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] op);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  task automatic drop_req(input logic id);
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  // Present one request and hold it until accepted; returns in the EXEC cycle.
  task automatic send(input logic id, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [2:0] op, output bit ok);
    ok = 1'b0;
    drive_req(id, a, b, op);
    #1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (id ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        sb.push_back(model(id, a, b, op));
      end else begin
        step();
      end
    end
    if (ok) begin
      step();
    end else begin
      n_checks++;
      $display("FAIL send_timeout: req%0d_ready never rose, required 1", id);
    end
    drop_req(id);
  endtask

  // Wait (bounded) for rsp_valid; returns observed and scoreboard entries.
  task automatic wait_rsp(output bit got, output exp_t act, output exp_t exp,
                          output int lat);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.rsp_valid === 1'b1) got = 1'b1;
      else begin step(); lat++; end
    end
    act.id  = bus.rsp_id;
    act.err = bus.rsp_err;
    act.res = bus.rsp_result;
    if (sb.size() > 0) exp = sb.pop_front();
    else begin exp.id = 1'bx; exp.err = 1'bx; exp.res = 'x; end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, output bit got, output exp_t act,
                       output exp_t exp, output int lat);
    bit ok;
    send(id, a, b, op, ok);
    wait_rsp(got, act, exp, lat);
    take_rsp();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    step(); step();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b need 0", bus.rsp_valid);
    else n_pass++;
    n_checks++;
    if (bus.rsp_result !== '0) $display("FAIL rst_rsp_result: got %h need 0", bus.rsp_result);
    else n_pass++;
    n_checks++;
    if (bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0)
      $display("FAIL rst_id_err: got id=%b err=%b need 0 0", bus.rsp_id, bus.rsp_err);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b need 0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
      $display("FAIL rst_ready: got %b%b need 00", bus.req0_ready, bus.req1_ready);
    else n_pass++;
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive_req(1'b0, 32'd10, 32'd5, 3'b000);
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL single_grant: got r0=%b r1=%b need 1 0", bus.req0_ready, bus.req1_ready);
    else n_pass++;
    sb.push_back(model(1'b0, 32'd10, 32'd5, 3'b000));
    step();
    drop_req(1'b0);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL single_exec: got busy=%b vld=%b need 1 0", bus.busy, bus.rsp_valid);
    else n_pass++;
    step();
    begin
      exp_t e = sb.pop_front();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e.res || bus.rsp_id !== e.id ||
          bus.rsp_err !== e.err)
        $display("FAIL single_rsp: got vld=%b res=%h id=%b err=%b need 1 %h %b %b",
                 bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_err, e.res, e.id, e.err);
      else n_pass++;
    end
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL single_idle: got busy=%b vld=%b need 0 0", bus.busy, bus.rsp_valid);
    else n_pass++;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_wrap_logic();
    logic [W-1:0] ta [3] = '{32'h0, 32'hAA, 32'h1};
    logic [W-1:0] tb [3] = '{32'h1, 32'hCC, 32'h3};
    logic [2:0]   top[3] = '{3'b001, 3'b100, 3'b101};
    for (int k = 0; k < 3; k++) begin
      bit got; exp_t act, exp; int lat;
      do_op(1'b1, ta[k], tb[k], top[k], got, act, exp, lat);
      n_checks++;
      if (!got || act.res !== exp.res || act.id !== exp.id || act.err !== exp.err)
        $display("FAIL wrap_rsp%0d: got vld=%b res=%h id=%b err=%b need res=%h id=%b err=%b",
                 k, got, act.res, act.id, act.err, exp.res, exp.id, exp.err);
      else n_pass++;
      n_checks++;
      if (lat !== 1) $display("FAIL wrap_latency%0d: got %0d need 1", k, lat);
      else n_pass++;
    end
  endtask

  task automatic test_arbitration();
    drive_req(1'b0, 32'd1, 32'd1, 3'b000);
    drive_req(1'b1, 32'hAA, 32'hCC, 3'b011);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit found = 1'b0;
      logic gid = 1'b0;
      bit got; exp_t act, exp; int lat;
      #1;
      for (int i = 0; i < 10 && !found; i++) begin
        if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) found = 1'b1;
        else step();
      end
      gid = bus.req1_ready;
      n_checks++;
      if (!found || (bus.req0_ready & bus.req1_ready) || gid !== k[0])
        $display("FAIL arb_order%0d: got found=%b r0=%b r1=%b need grant %0d",
                 k, found, bus.req0_ready, bus.req1_ready, k[0]);
      else n_pass++;
      if (found) begin
        if (gid) sb.push_back(model(1'b1, 32'hAA, 32'hCC, 3'b011));
        else     sb.push_back(model(1'b0, 32'd1, 32'd1, 3'b000));
      end
      step();
      wait_rsp(got, act, exp, lat);
      n_checks++;
      if (!got || act.res !== exp.res || act.id !== exp.id || act.err !== exp.err)
        $display("FAIL arb_rsp%0d: got vld=%b res=%h id=%b need res=%h id=%b",
                 k, got, act.res, act.id, exp.res, exp.id);
      else n_pass++;
      step();
    end
    drop_req(1'b0);
    drop_req(1'b1);
    bus.rsp_ready = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bit ok, got; exp_t act, exp, act2, exp2; int lat;
    send(1'b0, 32'd7, 32'd8, 3'b000, ok);
    wait_rsp(got, act, exp, lat);
    n_checks++;
    if (!got || act.res !== exp.res || act.id !== exp.id || act.err !== exp.err)
      $display("FAIL bp_rsp: got vld=%b res=%h id=%b need res=%h id=%b",
               got, act.res, act.id, exp.res, exp.id);
    else n_pass++;
    drive_req(1'b1, 32'h10, 32'h30, 3'b100);
    #1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== act.res || bus.rsp_id !== act.id ||
          bus.rsp_err !== act.err || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got vld=%b res=%h r1=%b need 1 %h 0",
                 c, bus.rsp_valid, bus.rsp_result, bus.req1_ready, act.res);
      else n_pass++;
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.req1_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL bp_resume: got r1=%b vld=%b need 1 0", bus.req1_ready, bus.rsp_valid);
    else n_pass++;
    if (bus.req1_ready === 1'b1) sb.push_back(model(1'b1, 32'h10, 32'h30, 3'b100));
    step();
    drop_req(1'b1);
    wait_rsp(got, act2, exp2, lat);
    take_rsp();
    n_checks++;
    if (!got || act2.res !== exp2.res || act2.id !== exp2.id || act2.err !== exp2.err)
      $display("FAIL bp_next_rsp: got vld=%b res=%h id=%b need res=%h id=%b",
               got, act2.res, act2.id, exp2.res, exp2.id);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [W-1:0] ta [2] = '{32'd3, 32'hAA};
    logic [W-1:0] tb [2] = '{32'd4, 32'hCC};
    logic [2:0]   top[2] = '{3'b111, 3'b010};
    for (int k = 0; k < 2; k++) begin
      bit got; exp_t act, exp; int lat;
      do_op(1'b0, ta[k], tb[k], top[k], got, act, exp, lat);
      n_checks++;
      if (!got || act.res !== exp.res || act.id !== exp.id || act.err !== exp.err)
        $display("FAIL illegal_rsp%0d: got vld=%b res=%h err=%b need res=%h err=%b",
                 k, got, act.res, act.err, exp.res, exp.err);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok, got, quiet; exp_t act, exp; int lat;
    send(1'b0, 32'd5, 32'd6, 3'b000, ok);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL midrst_async: got vld=%b busy=%b need 0 0", bus.rsp_valid, bus.busy);
    else n_pass++;
    if (sb.size() > 0) void'(sb.pop_back());
    drive_req(1'b0, 32'd20, 32'd22, 3'b000);
    drive_req(1'b1, 32'hF0, 32'h0F, 3'b011);
    quiet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
        quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL midrst_quiet: got activity during reset, need none");
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL midrst_first_grant: got r0=%b r1=%b need 1 0",
               bus.req0_ready, bus.req1_ready);
    else n_pass++;
    if (bus.req0_ready === 1'b1) sb.push_back(model(1'b0, 32'd20, 32'd22, 3'b000));
    step();
    drop_req(1'b0);
    drop_req(1'b1);
    wait_rsp(got, act, exp, lat);
    take_rsp();
    n_checks++;
    if (!got || act.res !== exp.res || act.id !== exp.id || act.err !== exp.err)
      $display("FAIL midrst_rsp: got vld=%b res=%h id=%b need res=%h id=%b",
               got, act.res, act.id, exp.res, exp.id);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap_logic();
    test_arbitration();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU (3-bit alu_control: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL).
- Accepts one operation at a time over a valid/ready handshake and registers the operands.
- Drives the instantiated alu, captures its result, and returns it with the requester ID on a single response channel.
- Sits between the decode/issue logic of two clients and the combinational ALU.

Parameters:
WIDTH, 32, operand/result width; must match the alu instance.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_a  input  WIDTH  requester 0 operand a.
req0_b  input  WIDTH  requester 0 operand b.
req0_op  input  3  requester 0 alu_control code.
req1_valid  input  1  requester 1 has an operation.
req1_ready  output  1  requester 1 operation accepted this cycle.
req1_a  input  WIDTH  requester 1 operand a.
req1_b  input  WIDTH  requester 1 operand b.
req1_op  input  3  requester 1 alu_control code.
rsp_valid  output  1  response holds a result.
rsp_ready  input  1  consumer takes the response.
rsp_result  output  WIDTH  ALU result.
rsp_id  output  1  requester that issued the operation.
rsp_err  output  1  op code was illegal (110/111).
busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - rsp_valid=0, rsp_result=0, rsp_id=0, rsp_err=0, busy=0, req*_ready=0.
  - Operand/op registers=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Any in-flight operation is dropped, with no response.
- FSM with three states:
  - IDLE: reqN_ready is combinational. It is 1 only for the granted requester, only when that requester's valid=1 and only in IDLE.
    - Grant rule: if exactly one valid, grant it. If both, grant !last_grant.
    - On accept (valid&ready): latch a, b, op and ID; last_grant<=ID; next state EXEC.
    - With no valid, stay in IDLE.
  - EXEC, exactly one cycle:
    - Registered operands drive the alu.
    - Legal op: rsp_result<=alu result, rsp_err<=0.
    - op 110/111: rsp_result<=0, rsp_err<=1.
    - rsp_id<=latched ID, rsp_valid<=1; next state RESP.
  - RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
    - On rsp_ready=1: rsp_valid<=0, next state IDLE.
    - No new request is accepted in RESP.
- Latency and throughput:
  - Accept at cycle T; rsp_valid=1 from cycle T+2.
  - Minimum initiation interval is 3 cycles (accept, EXEC, RESP with immediate rsp_ready).
- Arithmetic: modulo 2^WIDTH, so ADD/SUB wrap silently. SLL uses b[4:0] only (alu semantics).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
  - A requester that drops valid is skipped with no penalty.
  - last_grant updates only on accept.
- Requester side:
  - A requester must hold valid, a, b, op stable until ready.
  - Deasserting valid before ready is permitted (no accept occurs).
- rsp_ready while rsp_valid=0 is ignored.
- busy = (state != IDLE).
- Reset asserted mid-EXEC or mid-RESP: outputs go to reset values immediately. After release, the first accept occurs no earlier than the first clock edge with rst_n high.

Test Plan:
- Reset then single op: req0 a=10, b=5, op=000, rsp_ready=1 → req0_ready high at T. At T+2: rsp_valid=1, rsp_result=15, rsp_id=0, rsp_err=0. IDLE at T+3.
- Wrap/logic: req1 SUB a=0, b=1 → result 0xFFFFFFFF, rsp_id=1. Then req1 XOR a=0xAA, b=0xCC → 0x66. Then SLL a=1, b=3 → 8.
- Arbitration: both valid continuously for 4 ops (req0 ADD 1+1, req1 OR 0xAA|0xCC) → accept order 0,1,0,1. Results 2, 0xEE, 2, 0xEE with matching rsp_id.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable and req*_ready=0 throughout. Accept resumes the cycle after the rsp_ready handshake.
- Illegal op: req0 op=111, a=3, b=4 → rsp_result=0, rsp_err=1. The next legal op (AND 0xAA&0xCC) returns 0x88 with rsp_err=0.
- Reset mid-op: assert rst_n=0 during EXEC → rsp_valid=0, busy=0 asynchronously and no response appears. After release, tied requests grant requester 0 first.
